// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forwarding select encodings, mult/div latency defaults, register match helper
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 6;

  // $0 is hardwired to zero, so it never creates a dependency
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - mult/div occupancy counter; busy while HI/LO are pending, done on the write cycle
module muldiv_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // A start while already counting is dropped; decode stalls prevent it in practice
  always_comb begin
    count_d = count_q;
    if (count_q == '0) begin
      if (start) count_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Masked during reset so an aborted operation never shows a done pulse
  always_comb begin
    busy = !reset && (count_q != '0);
    done = !reset && (count_q == CNT_W'(1));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS pipeline forwarding, stall/flush and mult/div sequencing
// Optional stall performance counters under `define HAZ_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] write_reg_E,
  input  logic [4:0] write_reg_M,
  input  logic [4:0] write_reg_W,
  input  logic       reg_write_E,
  input  logic       reg_write_M,
  input  logic       reg_write_W,
  input  logic       mem_to_reg_E,
  input  logic       mem_to_reg_M,
  input  logic       branch_D,
  input  logic       muldiv_op_D,
  input  logic       hilo_read_D,
  input  logic       muldiv_start_E,
  input  logic       muldiv_is_div_E,
  output logic       forward_a_D,
  output logic       forward_b_D,
  output logic [1:0] forward_a_E,
  output logic [1:0] forward_b_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_E,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles,
`endif
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  logic lw_stall, br_stall, md_stall, any_stall;

  muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (muldiv_start_E),
    .is_div (muldiv_is_div_E),
    .busy   (muldiv_busy),
    .done   (muldiv_done)
  );

  // M is the younger producer, so it wins over W
  always_comb begin
    forward_a_E = FWD_NONE;
    forward_b_E = FWD_NONE;
    if (reg_write_M && reg_match(rs_E, write_reg_M))      forward_a_E = FWD_MEM;
    else if (reg_write_W && reg_match(rs_E, write_reg_W)) forward_a_E = FWD_WB;
    if (reg_write_M && reg_match(rt_E, write_reg_M))      forward_b_E = FWD_MEM;
    else if (reg_write_W && reg_match(rt_E, write_reg_W)) forward_b_E = FWD_WB;
    forward_a_D = reg_write_M && reg_match(rs_D, write_reg_M);
    forward_b_D = reg_write_M && reg_match(rt_D, write_reg_M);
    if (reset) begin
      forward_a_E = FWD_NONE;
      forward_b_E = FWD_NONE;
      forward_a_D = 1'b0;
      forward_b_D = 1'b0;
    end
  end

  always_comb begin
    lw_stall  = mem_to_reg_E && (reg_match(rs_D, write_reg_E) || reg_match(rt_D, write_reg_E));
    br_stall  = branch_D &&
                ((reg_write_E && (reg_match(rs_D, write_reg_E) || reg_match(rt_D, write_reg_E))) ||
                 (mem_to_reg_M && (reg_match(rs_D, write_reg_M) || reg_match(rt_D, write_reg_M))));
    md_stall  = (muldiv_op_D || hilo_read_D) && (muldiv_busy || muldiv_start_E) && !reset;
    any_stall = (lw_stall || br_stall || md_stall) && !reset;
    stall_F   = any_stall;
    stall_D   = any_stall;
    flush_E   = any_stall || reset;
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] md_stall_cycles_q, md_stall_cycles_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q    <= '0;
      md_stall_cycles_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      md_stall_cycles_q <= md_stall_cycles_d;
    end
  end

  always_comb begin
    stall_cycles_d    = stall_cycles_q;
    md_stall_cycles_d = md_stall_cycles_q;
    if (any_stall && (stall_cycles_q != 32'hFFFF_FFFF))   stall_cycles_d    = stall_cycles_q + 32'd1;
    if (md_stall && (md_stall_cycles_q != 32'hFFFF_FFFF)) md_stall_cycles_d = md_stall_cycles_q + 32'd1;
    stall_cycles    = stall_cycles_q;
    md_stall_cycles = md_stall_cycles_q;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (covers HAZ_PERF_CNT_EN when defined)
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
  logic       reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M;
  logic       branch_D, muldiv_op_D, hilo_read_D, muldiv_start_E, muldiv_is_div_E;
  logic       forward_a_D, forward_b_D, stall_F, stall_D, flush_E, muldiv_busy, muldiv_done;
  logic [1:0] forward_a_E, forward_b_E;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .write_reg_E(write_reg_E), .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
    .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M),
    .branch_D(branch_D), .muldiv_op_D(muldiv_op_D), .hilo_read_D(hilo_read_D),
    .muldiv_start_E(muldiv_start_E), .muldiv_is_div_E(muldiv_is_div_E),
    .forward_a_D(forward_a_D), .forward_b_D(forward_b_D),
    .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles),
`endif
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
  );

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0: return {30'd0, forward_a_E};
      1: return {30'd0, forward_b_E};
      2: return {31'd0, forward_a_D};
      3: return {31'd0, forward_b_D};
      4: return {31'd0, stall_F};
      5: return {31'd0, stall_D};
      6: return {31'd0, flush_E};
      7: return {31'd0, muldiv_busy};
      8: return {31'd0, muldiv_done};
`ifdef HAZ_PERF_CNT_EN
      9:  return stall_cycles;
      10: return md_stall_cycles;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input int sig, input logic [31:0] v, input string tag);
    exp_t e;
    e.sig = sig; e.exp = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_hz(input logic st, input logic fl, input string tag);
    push(4, {31'd0, st}, {tag, ".stall_F"});
    push(5, {31'd0, st}, {tag, ".stall_D"});
    push(6, {31'd0, fl}, {tag, ".flush_E"});
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Inputs are driven 1 time unit after posedge; outputs are sampled mid-cycle
  task automatic cyc();
    #3;
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    {rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W} = '0;
    {reg_write_E, reg_write_M, reg_write_W, mem_to_reg_E, mem_to_reg_M} = '0;
    {branch_D, muldiv_op_D, hilo_read_D, muldiv_start_E, muldiv_is_div_E} = '0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // reset: outputs forced even with a live forwarding match and a pending mfhi
    reg_write_M = 1'b1; write_reg_M = 5'd5; rs_E = 5'd5; rs_D = 5'd5; hilo_read_D = 1'b1;
    push(0, 32'd0, "rst.fwd_a_E");
    push(2, 32'd0, "rst.fwd_a_D");
    push(7, 32'd0, "rst.busy");
    push(8, 32'd0, "rst.done");
    exp_hz(1'b0, 1'b1, "rst");
    cyc();
    reset = 1'b0;
    clear_in();
`ifdef HAZ_PERF_CNT_EN
    push(9, 32'd0, "rst.stall_cycles");
    push(10, 32'd0, "rst.md_stall_cycles");
`endif
    exp_hz(1'b0, 1'b0, "idle");
    cyc();

    // forwarding priority
    reg_write_M = 1'b1; reg_write_W = 1'b1; write_reg_M = 5'd5; write_reg_W = 5'd5;
    rs_E = 5'd5; rt_E = 5'd7;
    push(0, 32'd2, "fwd.prio_mem");
    push(1, 32'd0, "fwd.b_none");
    cyc();
    reg_write_M = 1'b0; rt_E = 5'd5;
    push(0, 32'd1, "fwd.wb");
    push(1, 32'd1, "fwd.b_wb");
    cyc();
    rs_E = 5'd0;
    push(0, 32'd0, "fwd.rs_zero");
    cyc();
    reg_write_M = 1'b1; write_reg_M = 5'd0; write_reg_W = 5'd0; rt_E = 5'd0;
    push(1, 32'd0, "fwd.r0_never");
    cyc();
    clear_in();
    reg_write_M = 1'b1; write_reg_M = 5'd4; rs_D = 5'd4; rt_D = 5'd4;
    push(2, 32'd1, "fwd.a_D");
    push(3, 32'd1, "fwd.b_D");
    exp_hz(1'b0, 1'b0, "fwd.D_nostall");
    cyc();

    // load-use: lw $8 in E, add $9,$8,$3 in D
    clear_in();
    mem_to_reg_E = 1'b1; reg_write_E = 1'b1; write_reg_E = 5'd8; rs_D = 5'd8; rt_D = 5'd3;
    exp_hz(1'b1, 1'b1, "lu.stall");
    cyc();
    clear_in();
    mem_to_reg_M = 1'b1; reg_write_M = 1'b1; write_reg_M = 5'd8; rs_E = 5'd8; rt_E = 5'd3;
    push(0, 32'd2, "lu.fwd_a_E");
    exp_hz(1'b0, 1'b0, "lu.release");
    cyc();

    // div then mfhi
    clear_in();
    muldiv_start_E = 1'b1; muldiv_is_div_E = 1'b1;
    push(7, 32'd0, "div.issue_busy");
    exp_hz(1'b0, 1'b0, "div.issue");
    cyc();
    clear_in();
    hilo_read_D = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      push(7, 32'd1, $sformatf("div.busy%0d", k));
      push(8, {31'd0, (k == 32)}, $sformatf("div.done%0d", k));
      exp_hz(1'b1, 1'b1, $sformatf("div.c%0d", k));
      cyc();
    end
    push(7, 32'd0, "div.busy33");
    push(8, 32'd0, "div.done33");
    exp_hz(1'b0, 1'b0, "div.c33");
`ifdef HAZ_PERF_CNT_EN
    push(9, 32'd33, "perf.stall_cycles");
    push(10, 32'd32, "perf.md_stall_cycles");
`endif
    cyc();

    // mult with mult in D: stalls on start_E, then 4 busy cycles
    clear_in();
    muldiv_start_E = 1'b1; muldiv_op_D = 1'b1;
    exp_hz(1'b1, 1'b1, "mul.start_stall");
    cyc();
    muldiv_start_E = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push(8, {31'd0, (k == 4)}, $sformatf("mul.done%0d", k));
      exp_hz(1'b1, 1'b1, $sformatf("mul.c%0d", k));
      cyc();
    end
    push(7, 32'd0, "mul.idle");
    exp_hz(1'b0, 1'b0, "mul.release");
    cyc();

    // branch after ALU op: addi $4 in E, beq $4,$0 in D
    clear_in();
    reg_write_E = 1'b1; write_reg_E = 5'd4; branch_D = 1'b1; rs_D = 5'd4;
    exp_hz(1'b1, 1'b1, "br_alu.c1");
    cyc();
    reg_write_E = 1'b0; write_reg_E = 5'd0; reg_write_M = 1'b1; write_reg_M = 5'd4;
    exp_hz(1'b0, 1'b0, "br_alu.c2");
    push(2, 32'd1, "br_alu.fwd_a_D");
    push(3, 32'd0, "br_alu.fwd_b_D");
    cyc();

    // branch after load: two stall cycles
    clear_in();
    reg_write_E = 1'b1; mem_to_reg_E = 1'b1; write_reg_E = 5'd4; branch_D = 1'b1; rs_D = 5'd4;
    exp_hz(1'b1, 1'b1, "br_lw.c1");
    cyc();
    reg_write_E = 1'b0; mem_to_reg_E = 1'b0; write_reg_E = 5'd0;
    reg_write_M = 1'b1; mem_to_reg_M = 1'b1; write_reg_M = 5'd4;
    exp_hz(1'b1, 1'b1, "br_lw.c2");
    cyc();
    reg_write_M = 1'b0; mem_to_reg_M = 1'b0; write_reg_M = 5'd0;
    reg_write_W = 1'b1; write_reg_W = 5'd4;
    exp_hz(1'b0, 1'b0, "br_lw.c3");
    push(2, 32'd0, "br_lw.fwd_a_D");
    cyc();

    // reset at cycle 10 of a div aborts it
    clear_in();
    muldiv_start_E = 1'b1; muldiv_is_div_E = 1'b1;
    cyc();
    clear_in();
    hilo_read_D = 1'b1;
    for (int k = 1; k <= 9; k++) cyc();
    reset = 1'b1;
    push(7, 32'd0, "abort.rst_busy");
    exp_hz(1'b0, 1'b1, "abort.rst");
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      push(7, 32'd0, $sformatf("abort.busy%0d", k));
      push(8, 32'd0, $sformatf("abort.done%0d", k));
      cyc();
    end
    push(5, 32'd0, "abort.no_stall");
`ifdef HAZ_PERF_CNT_EN
    push(9, 32'd0, "abort.stall_cycles");
`endif
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
